// File: rtl/nv_host_int_evq_pkg.sv
// Shared defaults, derived widths and the merged event type for the
// host interrupt event-queue arbiter.
package nv_host_int_evq_pkg;

  localparam int EVQ_NUM_REQ   = 4;
  localparam int EVQ_PD_W      = 2;
  localparam int EVQ_MAX_BURST = 4;
  localparam int EVQ_SRC_W     = $clog2(EVQ_NUM_REQ);
  localparam int EVQ_BC_W      = $clog2(EVQ_MAX_BURST + 1);

  // Event as presented to the event queue: originating requester, then payload.
  typedef struct packed {
    logic [EVQ_SRC_W-1:0] src;
    logic [EVQ_PD_W-1:0]  pd;
  } evq_event_t;

endpackage

// File: rtl/nv_host_int_evq_rr_pick.sv
// Rotating-priority search: first eligible index at or after start_i,
// wrapping modulo NUM_REQ. Purely combinational.
module nv_host_int_evq_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [SRC_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [SRC_W-1:0]   idx_o,
  output logic               any_o
);

  int cand_s;

  // Walk the candidates in rotated order and keep the first eligible one.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(start_i) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!any_o && eligible_i[cand_s]) begin
        any_o            = 1'b1;
        idx_o            = SRC_W'(cand_s);
        onehot_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/nv_host_int_evq_arb.sv
// Merges NUM_REQ event requesters into one registered output stage.
// A requester keeps the grant for up to MAX_BURST consecutive events, after
// which (or as soon as it stops being eligible) round-robin moves on.
module nv_host_int_evq_arb
  import nv_host_int_evq_pkg::*;
#(
  parameter int NUM_REQ   = EVQ_NUM_REQ,
  parameter int PD_W      = EVQ_PD_W,
  parameter int MAX_BURST = EVQ_MAX_BURST
) (
  input  logic                                 sysclk_slcg,
  input  logic                                 reset_,
  input  logic [NUM_REQ-1:0]                   req_pvld,
  output logic [NUM_REQ-1:0]                   req_prdy,
  input  logic [NUM_REQ*PD_W-1:0]              req_pd,
  input  logic [NUM_REQ-1:0]                   req_mask,
  output logic                                 o_pvld,
  input  logic                                 o_prdy,
  output logic [$clog2(NUM_REQ)+PD_W-1:0]      o_pd,
  output logic                                 i_idle
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam int OPD_W = SRC_W + PD_W;

  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] pick_oh_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SRC_W-1:0]   pick_idx_s;
  logic [SRC_W-1:0]   start_s;
  logic [SRC_W-1:0]   win_idx_s;
  logic [PD_W-1:0]    sel_pd_s;
  logic               pick_any_s;
  logic               ready_bc_s;
  logic               hold_s;
  logic               xfer_s;

  logic               o_pvld_q, o_pvld_d;
  logic [OPD_W-1:0]   o_pd_q, o_pd_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]    burst_q, burst_d;

  assign eligible_s = req_pvld & ~req_mask;
  assign ready_bc_s = o_prdy || !o_pvld_q;

  // burst_q==0 means no grant since reset, so there is no burst to continue.
  assign hold_s = eligible_s[last_q] && (burst_q != {BC_W{1'b0}}) &&
                  (burst_q < BC_W'(MAX_BURST));

  // Round-robin search starts just after the last winner (index 0 after reset).
  assign start_s = (last_q == SRC_W'(NUM_REQ - 1)) ? {SRC_W{1'b0}} : (last_q + SRC_W'(1));

  nv_host_int_evq_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .eligible_i (eligible_s),
    .start_i    (start_s),
    .onehot_o   (pick_oh_s),
    .idx_o      (pick_idx_s),
    .any_o      (pick_any_s)
  );

  // Grant selection: burst hold first, else rotating pick; nothing while
  // the output stage is full or reset is asserted.
  always_comb begin
    grant_s   = '0;
    win_idx_s = last_q;
    if (ready_bc_s && reset_) begin
      if (hold_s) begin
        grant_s[last_q] = 1'b1;
        win_idx_s       = last_q;
      end else if (pick_any_s) begin
        grant_s   = pick_oh_s;
        win_idx_s = pick_idx_s;
      end else begin
        grant_s = '0;
      end
    end else begin
      grant_s = '0;
    end
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_pd_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        sel_pd_s = req_pd[i*PD_W +: PD_W];
      end else begin
        sel_pd_s = sel_pd_s;
      end
    end
  end

  assign xfer_s   = |(grant_s & req_pvld);
  assign req_prdy = grant_s;

  // Next state of output stage, last winner and burst counter.
  always_comb begin
    o_pvld_d = o_pvld_q;
    o_pd_d   = o_pd_q;
    last_d   = last_q;
    burst_d  = burst_q;
    if (xfer_s) begin
      o_pvld_d = 1'b1;
      o_pd_d   = {win_idx_s, sel_pd_s};
      last_d   = win_idx_s;
      if ((win_idx_s == last_q) && (burst_q < BC_W'(MAX_BURST))) begin
        burst_d = burst_q + BC_W'(1);
      end else begin
        burst_d = BC_W'(1);
      end
    end else if (ready_bc_s) begin
      o_pvld_d = 1'b0;
    end else begin
      o_pvld_d = o_pvld_q;
    end
  end

  // State registers; reset drops any held event and restarts the rotation.
  always_ff @(posedge sysclk_slcg or negedge reset_) begin
    if (!reset_) begin
      o_pvld_q <= 1'b0;
      o_pd_q   <= '0;
      last_q   <= SRC_W'(NUM_REQ - 1);
      burst_q  <= '0;
    end else begin
      o_pvld_q <= o_pvld_d;
      o_pd_q   <= o_pd_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
    end
  end

  assign o_pvld = o_pvld_q;
  assign o_pd   = o_pd_q;
  assign i_idle = !o_pvld_q;

endmodule

// File: tb/tb_nv_host_int_evq_arb.sv
// Bench for nv_host_int_evq_arb: directed scenarios plus randomized traffic,
// all checked against a transaction-level arbitration model.
module tb_nv_host_int_evq_arb;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       sysclk_slcg = 1'b0;
  logic       reset_;
  logic [3:0] req_pvld;
  logic [3:0] req_prdy;
  logic [7:0] req_pd;
  logic [3:0] req_mask;
  logic       o_pvld;
  logic       o_prdy;
  logic [3:0] o_pd;
  logic       i_idle;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int m_last, m_burst, m_hv, m_hsrc, m_hpd;

  // Values sampled by the last step()
  logic [3:0] prdy_seen;
  logic [3:0] pd_seen;
  logic       idle_seen;

  nv_host_int_evq_arb dut (
    .sysclk_slcg (sysclk_slcg),
    .reset_      (reset_),
    .req_pvld    (req_pvld),
    .req_prdy    (req_prdy),
    .req_pd      (req_pd),
    .req_mask    (req_mask),
    .o_pvld      (o_pvld),
    .o_prdy      (o_prdy),
    .o_pd        (o_pd),
    .i_idle      (i_idle)
  );

  always #5 sysclk_slcg = ~sysclk_slcg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Who should win this cycle, from the arbitration rules; -1 = nobody.
  function automatic int exp_grant();
    int c;
    if (!((o_prdy || m_hv == 0) && reset_)) return -1;
    if (m_burst > 0 && m_burst < MB && req_pvld[m_last] && !req_mask[m_last]) return m_last;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (req_pvld[c] && !req_mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive(input logic [3:0] pv, input logic [3:0] mk,
                       input logic [7:0] pd, input logic rdy);
    req_pvld = pv;
    req_mask = mk;
    req_pd   = pd;
    o_prdy   = rdy;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    int g;
    logic [3:0] ep;
    #1;
    g  = exp_grant();
    ep = (g >= 0) ? 4'(1 << g) : 4'b0000;
    prdy_seen = req_prdy;
    pd_seen   = o_pd;
    idle_seen = i_idle;
    chk("req_prdy", 32'(req_prdy), 32'(ep));
    chk("o_pvld",   32'(o_pvld),   32'(m_hv));
    chk("o_pd",     32'(o_pd),     32'((m_hsrc * 4) + m_hpd));
    chk("i_idle",   32'(i_idle),   32'(m_hv == 0));
    @(posedge sysclk_slcg);
    if (g >= 0) begin
      m_burst = (g == m_last && m_burst < MB) ? m_burst + 1 : 1;
      m_last  = g;
      m_hv    = 1;
      m_hsrc  = g;
      m_hpd   = (int'(req_pd) >> (g * 2)) & 3;
    end else if (o_prdy || m_hv == 0) begin
      m_hv = 0;
    end
    @(negedge sysclk_slcg);
  endtask

  // Asynchronous reset pulse in the middle of the clock-low phase.
  task automatic do_reset();
    #2;
    reset_ = 1'b0;
    #1;
    chk("rst_o_pvld", 32'(o_pvld),   32'd0);
    chk("rst_i_idle", 32'(i_idle),   32'd1);
    chk("rst_prdy",   32'(req_prdy), 32'd0);
    chk("rst_o_pd",   32'(o_pd),     32'd0);
    m_last = N - 1; m_burst = 0; m_hv = 0; m_hsrc = 0; m_hpd = 0;
    @(negedge sysclk_slcg);
    reset_ = 1'b1;
  endtask

  int tbl [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  initial begin
    reset_ = 1'b0;
    drive(4'b0000, 4'b0000, 8'h00, 1'b0);
    @(negedge sysclk_slcg);
    do_reset();

    // All requesting, no masks: bursts of four, rotating from index 0.
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rr_seq", 32'(prdy_seen), 32'(1 << tbl[i]));
      if (i > 0) chk("rr_src", 32'(pd_seen[3:2]), 32'(tbl[i-1]));
    end

    // Output stalled: nothing granted, held event stable; release grants at once.
    drive(4'b1111, 4'b0000, 8'hE4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_prdy", 32'(prdy_seen), 32'd0);
    end
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1);
    step();
    chk("stall_release", 32'(prdy_seen != 4'b0000), 32'd1);

    // Lone requester 2: ten back-to-back events, no bubble at burst wrap.
    do_reset();
    drive(4'b0100, 4'b0000, 8'hE4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("solo2_prdy", 32'(prdy_seen), 32'h4);
    end

    // Masking requester 1 mid-burst hands over to 2 immediately.
    do_reset();
    drive(4'b0010, 4'b0000, 8'hE4, 1'b1);
    step();
    step();
    drive(4'b1111, 4'b0010, 8'hE4, 1'b1);
    step();
    chk("mask_handover", 32'(prdy_seen), 32'h4);
    for (int i = 0; i < 4; i++) step();

    // Requester 3 payload 2'b10 -> o_pd 4'b1110 one cycle later.
    do_reset();
    drive(4'b1000, 4'b0000, 8'b10_00_00_00, 1'b1);
    step();
    chk("lat_idle0", 32'(idle_seen), 32'd1);
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    step();
    chk("lat_opd", 32'(pd_seen), 32'hE);
    chk("lat_idle1", 32'(idle_seen), 32'd0);
    step();
    chk("lat_idle2", 32'(idle_seen), 32'd1);

    // Reset with an event held and burst at 3; first grant afterwards is 0.
    do_reset();
    drive(4'b0001, 4'b0000, 8'hE4, 1'b1);
    for (int i = 0; i < 3; i++) step();
    do_reset();
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1);
    step();
    chk("post_rst_first", 32'(prdy_seen), 32'h1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
